dram_refresh: RTL and testbench



---
 rtl/dram_pkg.sv | 29 ++
 rtl/dram_refresh_if.sv | 23 ++
 rtl/dram_refresh_timer.sv | 59 +++++
 rtl/dram_refresh.sv | 133 +++++++++++++
 tb/tb_dram_refresh.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/dram_pkg.sv
// Shared DRAM definitions: refresh FSM encoding, default strobe timing and the
// idle strobe level used by both the refresh sequencer and the DRAM controller.
package dram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_CAS  = 3'd2,
        ST_RAS  = 3'd3,
        ST_PRE  = 3'd4
    } ref_state_e;

    // 512 BCLKs at 33 MHz stays under the 15.6 us refresh period.
    localparam int unsigned REFRESH_CYCLES_DEF = 512;
    localparam int unsigned TCSR_CLKS_DEF      = 1;
    localparam int unsigned TRAS_CLKS_DEF      = 3;
    localparam int unsigned TRP_CLKS_DEF       = 2;
    localparam int unsigned MAX_PENDING_DEF    = 7;

    localparam logic [3:0] STROBE_IDLE = 4'hF;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dram_refresh_if.sv
// Handshake and strobe bundle between the refresh sequencer (slave) and the
// DRAM controller (master), which merges the strobes with its own.
interface dram_refresh_if;

    logic       ref_gnt;
    logic       ref_req;
    logic       ref_busy;
    logic       ref_done;
    logic       ref_overrun;
    logic [3:0] nRAS;
    logic [3:0] nCAS;

    modport master (
        output ref_gnt,
        input  ref_req, ref_busy, ref_done, ref_overrun, nRAS, nCAS
    );

    modport slave (
        input  ref_gnt,
        output ref_req, ref_busy, ref_done, ref_overrun, nRAS, nCAS
    );

endinterface

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter plus the saturating count of refreshes
// owed; overrun latches once a tick arrives with the counter already full.
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = REFRESH_CYCLES_DEF,
    parameter int unsigned MAX_PENDING    = MAX_PENDING_DEF
) (
    input  logic clk,
    input  logic nRESET,
    input  logic start_i,
    output logic pending_nz_o,
    output logic overrun_o
);

    localparam int unsigned CNT_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              overrun_q, overrun_d;
    logic              tick;

    always_comb begin
        tick      = (cnt_q == CNT_LAST);
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        pend_d    = pend_q;
        overrun_d = overrun_q;
        // A tick and a start in the same clock cancel out.
        if (tick && !start_i) begin
            if (pend_q == PEND_MAX) begin
                overrun_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (!tick && start_i && (pend_q != '0)) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            cnt_q     <= '0;
            pend_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending_nz_o = (pend_q != '0);
    assign overrun_o    = overrun_q;

endmodule

// File: rtl/dram_refresh.sv
// CAS-before-RAS refresh sequencer: requests an idle bus slot, then walks all
// nRAS/nCAS lines through CAS setup, RAS active and precharge while granted.
module dram_refresh
    import dram_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = REFRESH_CYCLES_DEF,
    parameter int unsigned TCSR_CLKS      = TCSR_CLKS_DEF,
    parameter int unsigned TRAS_CLKS      = TRAS_CLKS_DEF,
    parameter int unsigned TRP_CLKS       = TRP_CLKS_DEF,
    parameter int unsigned MAX_PENDING    = MAX_PENDING_DEF
) (
    input  logic          clk,
    input  logic          nRESET,
    dram_refresh_if.slave bus
);

    if (REFRESH_CYCLES == 0 || TCSR_CLKS == 0 || TRAS_CLKS == 0 ||
        TRP_CLKS == 0 || MAX_PENDING == 0) begin : g_param_check
        $error("dram_refresh: all timing parameters must be non-zero");
    end

    localparam int unsigned PH_MAX = max3(TCSR_CLKS, TRAS_CLKS, TRP_CLKS);
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0] PH_CSR = PH_W'(TCSR_CLKS - 1);
    localparam logic [PH_W-1:0] PH_RAS = PH_W'(TRAS_CLKS - 1);
    localparam logic [PH_W-1:0] PH_RP  = PH_W'(TRP_CLKS - 1);

    ref_state_e      state_q;
    logic [PH_W-1:0] phase_q;
    logic            req_q;
    logic            busy_q;
    logic            done_q;
    logic [3:0]      nras_q;
    logic [3:0]      ncas_q;
    logic            start;
    logic            pending_nz;
    logic            overrun;

    assign start = (state_q == ST_REQ) && bus.ref_gnt;

    dram_refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES),
        .MAX_PENDING    (MAX_PENDING)
    ) u_timer (
        .clk          (clk),
        .nRESET       (nRESET),
        .start_i      (start),
        .pending_nz_o (pending_nz),
        .overrun_o    (overrun)
    );

    // Every phase reloads the shared down-counter on entry and leaves at zero.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nras_q  <= STROBE_IDLE;
            ncas_q  <= STROBE_IDLE;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pending_nz) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (start) begin
                        state_q <= ST_CAS;
                        req_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        ncas_q  <= 4'h0;
                        phase_q <= PH_CSR;
                    end
                end
                ST_CAS: begin
                    if (phase_q == '0) begin
                        state_q <= ST_RAS;
                        nras_q  <= 4'h0;
                        phase_q <= PH_RAS;
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end
                ST_RAS: begin
                    if (phase_q == '0) begin
                        state_q <= ST_PRE;
                        nras_q  <= STROBE_IDLE;
                        ncas_q  <= STROBE_IDLE;
                        phase_q <= PH_RP;
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end
                ST_PRE: begin
                    if (phase_q == '0) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        // Owed refreshes run back-to-back without an IDLE gap.
                        if (pending_nz) begin
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    nras_q  <= STROBE_IDLE;
                    ncas_q  <= STROBE_IDLE;
                end
            endcase
        end
    end

    assign bus.ref_req     = req_q;
    assign bus.ref_busy    = busy_q;
    assign bus.ref_done    = done_q;
    assign bus.ref_overrun = overrun;
    assign bus.nRAS        = nras_q;
    assign bus.nCAS        = ncas_q;

endmodule

// File: tb/tb_dram_refresh.sv
// Directed bench for dram_refresh: a 512-clock instance and a 16-clock instance
// share clock and reset; edge numbers count rising edges after reset release.
module tb_dram_refresh;

    logic clk = 1'b0;
    logic nRESET;

    always #5 clk = ~clk;

    dram_refresh_if bus_a ();
    dram_refresh_if bus_b ();

    dram_refresh u_dut (
        .clk    (clk),
        .nRESET (nRESET),
        .bus    (bus_a)
    );

    dram_refresh #(.REFRESH_CYCLES(16)) u_fast (
        .clk    (clk),
        .nRESET (nRESET),
        .bus    (bus_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_n = 0;

    typedef struct {
        int          fast;
        int          edge_no;
        logic        gnt_next;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] pack(input logic r, input logic b, input logic d,
                                         input logic [3:0] ras, input logic [3:0] cas);
        return {21'b0, r, b, d, ras, cas};
    endfunction

    function automatic logic [31:0] obs(input int fast);
        if (fast != 0)
            return pack(bus_b.ref_req, bus_b.ref_busy, bus_b.ref_done, bus_b.nRAS, bus_b.nCAS);
        return pack(bus_a.ref_req, bus_a.ref_busy, bus_a.ref_done, bus_a.nRAS, bus_a.nCAS);
    endfunction

    task automatic add_vec(input int fast, input int e, input logic g, input logic r,
                           input logic b, input logic d, input logic [3:0] ras,
                           input logic [3:0] cas);
        vec_t v;
        v.fast     = fast;
        v.edge_no  = e;
        v.gnt_next = g;
        v.exp      = pack(r, b, d, ras, cas);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got 0x%0h, want 0x%0h", name, edge_n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) step();
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_outputs_a", obs(0), pack(1'b0, 1'b0, 1'b0, 4'hF, 4'hF));
        chk("reset_outputs_b", obs(1), pack(1'b0, 1'b0, 1'b0, 4'hF, 4'hF));
        chk("reset_overrun_a", 32'(bus_a.ref_overrun), 32'd0);
        chk("reset_overrun_b", 32'(bus_b.ref_overrun), 32'd0);
        nRESET = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_a;
        int cnt_b;
        logic saw_req;

        nRESET        = 1'b0;
        bus_a.ref_gnt = 1'b1;
        bus_b.ref_gnt = 1'b0;

        // Fast instance: single-clock grant pulse in REQ. Tick at 16, REQ at 17.
        add_vec(1, 16, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF);
        add_vec(1, 17, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
        add_vec(1, 20, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
        add_vec(1, 21, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
        add_vec(1, 22, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        add_vec(1, 23, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        add_vec(1, 24, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        add_vec(1, 25, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF);
        add_vec(1, 26, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF);
        add_vec(1, 27, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF);
        add_vec(1, 28, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF);
        // Default instance, grant tied high: tick at 512, REQ 513, CAS 514.
        add_vec(0, 511, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF);
        add_vec(0, 512, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF);
        add_vec(0, 513, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
        add_vec(0, 514, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
        add_vec(0, 515, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        add_vec(0, 516, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        add_vec(0, 517, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        add_vec(0, 518, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF);
        add_vec(0, 519, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF);
        add_vec(0, 520, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF);
        add_vec(0, 521, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF);

        do_reset();
        foreach (vecs[i]) begin
            run_to(vecs[i].edge_no);
            chk(vecs[i].fast != 0 ? "vec_fast" : "vec_default", obs(vecs[i].fast), vecs[i].exp);
            if (vecs[i].fast != 0) bus_b.ref_gnt = vecs[i].gnt_next;
            else                   bus_a.ref_gnt = vecs[i].gnt_next;
        end

        // Second interval repeats 512 clocks later; reset lands inside RAS.
        run_to(1025);
        chk("repeat_req", 32'(bus_a.ref_req), 32'd1);
        run_to(1026);
        chk("repeat_cas_busy", 32'(bus_a.ref_busy), 32'd1);
        run_to(1028);
        chk("in_ras_nras", 32'(bus_a.nRAS), 32'h0);
        #2;
        nRESET = 1'b0;
        #1;
        chk("async_rst_nras", 32'(bus_a.nRAS), 32'hF);
        chk("async_rst_ncas", 32'(bus_a.nCAS), 32'hF);
        chk("async_rst_busy", 32'(bus_a.ref_busy), 32'd0);
        @(posedge clk);
        #1;
        nRESET = 1'b1;
        edge_n = 0;
        cnt_a  = 0;
        for (int e = 1; e <= 512; e++) begin
            step();
            if (bus_a.ref_req) cnt_a++;
        end
        chk("post_rst_early_req", 32'(cnt_a), 32'd0);
        step();
        chk("post_rst_first_req", 32'(bus_a.ref_req), 32'd1);

        // Three ticks with no grant: REQ holds, then three back-to-back sequences.
        bus_a.ref_gnt = 1'b0;
        do_reset();
        run_to(513);
        cnt_a = 0;
        while (edge_n < 1536) begin
            step();
            if (!bus_a.ref_req) cnt_a++;
        end
        chk("req_held_3_ticks", 32'(cnt_a), 32'd0);
        bus_a.ref_gnt = 1'b1;
        cnt_a   = 0;
        cnt_b   = 0;
        saw_req = 1'b0;
        while (edge_n < 1600) begin
            step();
            if (bus_a.ref_done) cnt_a++;
            if (bus_a.ref_busy) cnt_b++;
            if (edge_n == 1543) begin
                chk("b2b_gap_busy", 32'(bus_a.ref_busy), 32'd0);
                saw_req = bus_a.ref_req;
            end
        end
        chk("b2b_gap_req", 32'(saw_req), 32'd1);
        chk("b2b_done_count", 32'(cnt_a), 32'd3);
        chk("b2b_busy_clocks", 32'(cnt_b), 32'd18);
        chk("b2b_idle_req", 32'(bus_a.ref_req), 32'd0);
        chk("b2b_no_overrun", 32'(bus_a.ref_overrun), 32'd0);

        // Fast instance, 8 ticks without grant: saturates at 7 on tick 8 (edge 128).
        // 7 owed plus ticks 144/160/176 (+1 each) and 192 (cancels its start)
        // give CAS at 129,136,...,199: 11 sequences, done pulses through 205.
        bus_b.ref_gnt = 1'b0;
        do_reset();
        run_to(127);
        chk("overrun_before_sat", 32'(bus_b.ref_overrun), 32'd0);
        step();
        chk("overrun_at_sat", 32'(bus_b.ref_overrun), 32'd1);
        bus_b.ref_gnt = 1'b1;
        cnt_b = 0;
        while (edge_n < 208) begin
            step();
            if (bus_b.ref_done) cnt_b++;
        end
        chk("sat_done_count", 32'(cnt_b), 32'd11);
        chk("overrun_sticky", 32'(bus_b.ref_overrun), 32'd1);

        // Grant lands on the tick clock: CAS at 32 leaves pending at 1.
        bus_b.ref_gnt = 1'b0;
        do_reset();
        run_to(31);
        bus_b.ref_gnt = 1'b1;
        step();
        chk("coinc_cas_busy", 32'(bus_b.ref_busy), 32'd1);
        run_to(38);
        chk("coinc_done1", 32'(bus_b.ref_done), 32'd1);
        chk("coinc_rereq", 32'(bus_b.ref_req), 32'd1);
        step();
        chk("coinc_second_cas", obs(1), pack(1'b0, 1'b1, 1'b0, 4'hF, 4'h0));
        run_to(45);
        chk("coinc_done2", obs(1), pack(1'b0, 1'b0, 1'b1, 4'hF, 4'hF));
        step();
        chk("coinc_idle", obs(1), pack(1'b0, 1'b0, 1'b0, 4'hF, 4'hF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
